// File: rtl/mano_ctrl_seq.sv
// Timing and control unit for the Mano basic computer: SC, S and I registers plus strobe decode.
// Define MANO_INTERRUPT_EN to compile in the R/IEN interrupt cycle and the ION/IOF instructions.
module mano_ctrl_seq #(
  parameter int unsigned SC_W         = 4,
  parameter bit          RUN_ON_RESET = 1'b1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            START,
  input  logic [15:0]     IR_Q,
  input  logic            AC_SIGN,
  input  logic            AC_ZERO,
  input  logic            E_Q,
  input  logic            DR_ZERO,
  input  logic            FGI,
  input  logic            FGO,
  output logic [SC_W-1:0] SC_Q,
  output logic            S_Q,
  output logic            I_Q,
  output logic [2:0]      BUS_SEL,
  output logic            LD_AR,
  output logic            INR_AR,
  output logic            CLR_AR,
  output logic            LD_PC,
  output logic            INR_PC,
  output logic            CLR_PC,
  output logic            LD_DR,
  output logic            INR_DR,
  output logic            LD_IR,
  output logic            LD_TR,
  output logic            INR_AC,
  output logic            MEM_RD,
  output logic            MEM_WR,
  output logic [2:0]      AC_OP,
  output logic [1:0]      E_OP
);

  localparam logic [2:0] BusNone = 3'd0;
  localparam logic [2:0] BusAr   = 3'd1;
  localparam logic [2:0] BusPc   = 3'd2;
  localparam logic [2:0] BusDr   = 3'd3;
  localparam logic [2:0] BusAc   = 3'd4;
  localparam logic [2:0] BusIr   = 3'd5;
  localparam logic [2:0] BusTr   = 3'd6;
  localparam logic [2:0] BusMem  = 3'd7;

  logic [SC_W-1:0] sc_q, sc_d;
  logic s_q, s_d, i_q, i_d, r_q, r_d, ien_q, ien_d;
  logic fin, hlt, int_cyc, d7;

  assign d7      = (IR_Q[14:12] == 3'd7);
  // R only rises after T2, so R=1 during T0..T2 always means the interrupt cycle.
  assign int_cyc = r_q && (sc_q <= SC_W'(2));

  assign SC_Q = sc_q;
  assign S_Q  = s_q;
  assign I_Q  = i_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sc_q  <= '0;
      s_q   <= RUN_ON_RESET;
      i_q   <= 1'b0;
      r_q   <= 1'b0;
      ien_q <= 1'b0;
    end else begin
      sc_q  <= sc_d;
      s_q   <= s_d;
      i_q   <= i_d;
      r_q   <= r_d;
      ien_q <= ien_d;
    end
  end

`ifdef MANO_INTERRUPT_EN
  logic ion, iof;
  assign ion = s_q && d7 && i_q && (sc_q == SC_W'(3)) && (IR_Q == 16'hF080);
  assign iof = s_q && d7 && i_q && (sc_q == SC_W'(3)) && (IR_Q == 16'hF040);
`else
  logic unused_int;
  assign unused_int = FGI ^ FGO ^ ien_q;
`endif

  always_comb begin
    sc_d  = sc_q;
    s_d   = s_q;
    i_d   = i_q;
    r_d   = r_q;
    ien_d = ien_q;
    if (!s_q) begin
      if (START) begin
        s_d  = 1'b1;
        sc_d = '0;
      end
    end else begin
      sc_d = fin ? '0 : sc_q + 1'b1;
      if (hlt) s_d = 1'b0;
      if (!int_cyc && (sc_q == SC_W'(2))) i_d = IR_Q[15];
`ifdef MANO_INTERRUPT_EN
      if ((sc_q > SC_W'(2)) && ien_q && (FGI || FGO)) r_d = 1'b1;
      if (int_cyc && (sc_q == SC_W'(2))) begin
        r_d   = 1'b0;
        ien_d = 1'b0;
      end
      if (ion) ien_d = 1'b1;
      if (iof) ien_d = 1'b0;
`else
      r_d   = 1'b0;
      ien_d = 1'b0;
`endif
    end
  end

  always_comb begin
    BUS_SEL = BusNone;
    LD_AR   = 1'b0;
    INR_AR  = 1'b0;
    CLR_AR  = 1'b0;
    LD_PC   = 1'b0;
    INR_PC  = 1'b0;
    CLR_PC  = 1'b0;
    LD_DR   = 1'b0;
    INR_DR  = 1'b0;
    LD_IR   = 1'b0;
    LD_TR   = 1'b0;
    INR_AC  = 1'b0;
    MEM_RD  = 1'b0;
    MEM_WR  = 1'b0;
    AC_OP   = 3'd0;
    E_OP    = 2'd0;
    fin     = 1'b0;
    hlt     = 1'b0;
    // Gating on RST_N keeps the T0 decode quiet while reset holds S=1.
    if (RST_N && s_q) begin
      if (int_cyc) begin
        case (sc_q)
          SC_W'(0): begin CLR_AR = 1'b1; BUS_SEL = BusPc; LD_TR = 1'b1; end
          SC_W'(1): begin BUS_SEL = BusTr; MEM_WR = 1'b1; CLR_PC = 1'b1; end
          default:  begin INR_PC = 1'b1; fin = 1'b1; end
        endcase
      end else begin
        case (sc_q)
          SC_W'(0): begin BUS_SEL = BusPc; LD_AR = 1'b1; end
          SC_W'(1): begin BUS_SEL = BusMem; MEM_RD = 1'b1; LD_IR = 1'b1; INR_PC = 1'b1; end
          SC_W'(2): begin BUS_SEL = BusIr; LD_AR = 1'b1; end
          SC_W'(3): begin
            if (!d7) begin
              if (i_q) begin BUS_SEL = BusMem; MEM_RD = 1'b1; LD_AR = 1'b1; end
            end else begin
              fin = 1'b1;
              if (!i_q) begin
                if (IR_Q[11])     AC_OP = 3'd4;
                else if (IR_Q[9]) AC_OP = 3'd5;
                else if (IR_Q[7]) AC_OP = 3'd6;
                else if (IR_Q[6]) AC_OP = 3'd7;
                if (IR_Q[10])     E_OP = 2'd1;
                else if (IR_Q[8]) E_OP = 2'd2;
                INR_AC = IR_Q[5];
                INR_PC = (IR_Q[4] && !AC_SIGN) || (IR_Q[3] && AC_SIGN) ||
                         (IR_Q[2] && AC_ZERO) || (IR_Q[1] && !E_Q);
                hlt    = IR_Q[0];
              end
            end
          end
          SC_W'(4): begin
            case (IR_Q[14:12])
              3'd0, 3'd1, 3'd2, 3'd6: begin BUS_SEL = BusMem; MEM_RD = 1'b1; LD_DR = 1'b1; end
              3'd3: begin BUS_SEL = BusAc; MEM_WR = 1'b1; fin = 1'b1; end
              3'd4: begin BUS_SEL = BusAr; LD_PC = 1'b1; fin = 1'b1; end
              3'd5: begin BUS_SEL = BusPc; MEM_WR = 1'b1; INR_AR = 1'b1; end
              default: fin = 1'b1;
            endcase
          end
          SC_W'(5): begin
            case (IR_Q[14:12])
              3'd0: begin AC_OP = 3'd1; fin = 1'b1; end
              3'd1: begin AC_OP = 3'd2; fin = 1'b1; end
              3'd2: begin AC_OP = 3'd3; fin = 1'b1; end
              3'd5: begin BUS_SEL = BusAr; LD_PC = 1'b1; fin = 1'b1; end
              3'd6: INR_DR = 1'b1;
              default: fin = 1'b1;
            endcase
          end
          SC_W'(6): begin
            if (IR_Q[14:12] == 3'd6) begin
              BUS_SEL = BusDr;
              MEM_WR  = 1'b1;
              INR_PC  = DR_ZERO;
            end
            fin = 1'b1;
          end
          default: fin = 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mano_ctrl_seq.sv
// Bench for mano_ctrl_seq: per-cycle vector table through a scoreboard queue, plus reset corners.
module tb_mano_ctrl_seq;

  logic        CLK = 1'b0, RST_N = 1'b0, START = 1'b0;
  logic [15:0] IR_Q = 16'h0;
  logic        AC_SIGN = 1'b0, AC_ZERO = 1'b0, E_Q = 1'b0, DR_ZERO = 1'b0, FGI = 1'b0, FGO = 1'b0;
  logic [3:0]  SC_Q;
  logic        S_Q, I_Q;
  logic [2:0]  BUS_SEL, AC_OP;
  logic [1:0]  E_OP;
  logic LD_AR, INR_AR, CLR_AR, LD_PC, INR_PC, CLR_PC, LD_DR, INR_DR, LD_IR, LD_TR, INR_AC;
  logic MEM_RD, MEM_WR;

  mano_ctrl_seq #(.SC_W(4), .RUN_ON_RESET(1'b1)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .IR_Q(IR_Q), .AC_SIGN(AC_SIGN), .AC_ZERO(AC_ZERO),
    .E_Q(E_Q), .DR_ZERO(DR_ZERO), .FGI(FGI), .FGO(FGO), .SC_Q(SC_Q), .S_Q(S_Q), .I_Q(I_Q),
    .BUS_SEL(BUS_SEL), .LD_AR(LD_AR), .INR_AR(INR_AR), .CLR_AR(CLR_AR), .LD_PC(LD_PC),
    .INR_PC(INR_PC), .CLR_PC(CLR_PC), .LD_DR(LD_DR), .INR_DR(INR_DR), .LD_IR(LD_IR),
    .LD_TR(LD_TR), .INR_AC(INR_AC), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .AC_OP(AC_OP), .E_OP(E_OP)
  );

  always #5 CLK = ~CLK;

  localparam logic [12:0] MLdAr  = 13'h1000, MInrAr = 13'h0800, MLdPc = 13'h0200;
  localparam logic [12:0] MInrPc = 13'h0100, MLdDr  = 13'h0040, MInrDr = 13'h0020;
  localparam logic [12:0] MLdIr  = 13'h0010, MInrAc = 13'h0004, MRd = 13'h0002, MWr = 13'h0001;

  typedef struct packed {
    logic [3:0]  sc;
    logic        s;
    logic        i;
    logic [2:0]  bus;
    logic [12:0] st;
    logic [2:0]  ac;
    logic [1:0]  eo;
  } exp_t;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  fl;  // {AC_SIGN, AC_ZERO, E_Q, DR_ZERO}
    logic        start;
    exp_t        e;
  } vec_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  int          sb_idx[$];
  int          n_checks = 0, n_errors = 0;
  logic [15:0] cur_ir = 16'h0;
  logic [3:0]  cur_fl = 4'h0;
  logic        cur_i = 1'b0;
  exp_t        mon_e, mon_a;
  int          mon_k, w;

  function automatic logic [12:0] strb();
    return {LD_AR, INR_AR, CLR_AR, LD_PC, INR_PC, CLR_PC, LD_DR, INR_DR, LD_IR, LD_TR, INR_AC,
            MEM_RD, MEM_WR};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_row(input logic [3:0] sc, input logic s, input logic [2:0] bus,
                          input logic [12:0] st, input logic [2:0] ac, input logic [1:0] eo,
                          input logic start);
    vec_t v;
    v.ir = cur_ir;  v.fl = cur_fl;  v.start = start;
    v.e.sc = sc;  v.e.s = s;  v.e.i = cur_i;  v.e.bus = bus;
    v.e.st = st;  v.e.ac = ac;  v.e.eo = eo;
    tbl.push_back(v);
  endtask

  task automatic fetch(input logic [15:0] ir, input logic [3:0] fl);
    cur_ir = ir;
    cur_fl = fl;
    push_row(4'd0, 1'b1, 3'd2, MLdAr, 3'd0, 2'd0, 1'b0);
    push_row(4'd1, 1'b1, 3'd7, MRd | MLdIr | MInrPc, 3'd0, 2'd0, 1'b0);
    push_row(4'd2, 1'b1, 3'd5, MLdAr, 3'd0, 2'd0, 1'b0);
    cur_i = ir[15];
  endtask

  task automatic ex(input logic [3:0] sc, input logic [2:0] bus, input logic [12:0] st,
                    input logic [2:0] ac, input logic [1:0] eo);
    push_row(sc, 1'b1, bus, st, ac, eo, 1'b0);
  endtask

  task automatic reg_ref(input logic [15:0] ir, input logic [3:0] fl, input logic [12:0] st,
                         input logic [2:0] ac, input logic [1:0] eo);
    fetch(ir, fl);
    ex(4'd3, 3'd0, st, ac, eo);
  endtask

  task automatic mem_rd_exec(input logic [15:0] ir, input logic [2:0] ac);
    fetch(ir, 4'h0);
    ex(4'd3, 3'd0, 13'h0, 3'd0, 2'd0);
    ex(4'd4, 3'd7, MRd | MLdDr, 3'd0, 2'd0);
    ex(4'd5, 3'd0, 13'h0, ac, 2'd0);
  endtask

  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_k = sb_idx.pop_front();
      mon_a = {SC_Q, S_Q, I_Q, BUS_SEL, strb(), AC_OP, E_OP};
      n_checks++;
      if (mon_a !== mon_e) begin
        n_errors++;
        $display("FAIL row%0d sc/s/i/bus/strb/ac/eop got %0d/%b/%b/%0d/%h/%0d/%0d want %0d/%b/%b/%0d/%h/%0d/%0d",
                 mon_k, mon_a.sc, mon_a.s, mon_a.i, mon_a.bus, mon_a.st, mon_a.ac, mon_a.eo,
                 mon_e.sc, mon_e.s, mon_e.i, mon_e.bus, mon_e.st, mon_e.ac, mon_e.eo);
      end
    end
  end

  initial begin
    // Indirect AND
    fetch(16'h8123, 4'h0);
    ex(4'd3, 3'd7, MRd | MLdAr, 3'd0, 2'd0);
    ex(4'd4, 3'd7, MRd | MLdDr, 3'd0, 2'd0);
    ex(4'd5, 3'd0, 13'h0, 3'd1, 2'd0);
    // ISZ with DR reaching zero, then not
    for (int z = 1; z >= 0; z--) begin
      fetch(16'h6050, {3'b000, z[0]});
      ex(4'd3, 3'd0, 13'h0, 3'd0, 2'd0);
      ex(4'd4, 3'd7, MRd | MLdDr, 3'd0, 2'd0);
      ex(4'd5, 3'd0, MInrDr, 3'd0, 2'd0);
      ex(4'd6, 3'd3, z[0] ? (MWr | MInrPc) : MWr, 3'd0, 2'd0);
    end
    mem_rd_exec(16'h1010, 3'd2);
    mem_rd_exec(16'h2010, 3'd3);
    fetch(16'h3010, 4'h0);
    ex(4'd3, 3'd0, 13'h0, 3'd0, 2'd0);
    ex(4'd4, 3'd4, MWr, 3'd0, 2'd0);
    fetch(16'h4010, 4'h0);
    ex(4'd3, 3'd0, 13'h0, 3'd0, 2'd0);
    ex(4'd4, 3'd1, MLdPc, 3'd0, 2'd0);
    fetch(16'h5010, 4'h0);
    ex(4'd3, 3'd0, 13'h0, 3'd0, 2'd0);
    ex(4'd4, 3'd2, MWr | MInrAr, 3'd0, 2'd0);
    ex(4'd5, 3'd1, MLdPc, 3'd0, 2'd0);
    // Register reference: priorities and skips
    reg_ref(16'h7A00, 4'h0, 13'h0, 3'd4, 2'd0);
    reg_ref(16'h7004, 4'b0100, MInrPc, 3'd0, 2'd0);
    reg_ref(16'h7004, 4'b0000, 13'h0, 3'd0, 2'd0);
    reg_ref(16'h7500, 4'h0, 13'h0, 3'd0, 2'd1);
    reg_ref(16'h7100, 4'h0, 13'h0, 3'd0, 2'd2);
    reg_ref(16'h7280, 4'h0, 13'h0, 3'd5, 2'd0);
    reg_ref(16'h70C0, 4'h0, 13'h0, 3'd6, 2'd0);
    reg_ref(16'h7040, 4'h0, 13'h0, 3'd7, 2'd0);
    reg_ref(16'h7020, 4'h0, MInrAc, 3'd0, 2'd0);
    reg_ref(16'h7010, 4'b0000, MInrPc, 3'd0, 2'd0);
    reg_ref(16'h7008, 4'b0000, 13'h0, 3'd0, 2'd0);
    reg_ref(16'h7008, 4'b1000, MInrPc, 3'd0, 2'd0);
    reg_ref(16'h7002, 4'b0000, MInrPc, 3'd0, 2'd0);
    reg_ref(16'h7002, 4'b0010, 13'h0, 3'd0, 2'd0);
    // ION is a plain I/O end in this build
    reg_ref(16'hF080, 4'h0, 13'h0, 3'd0, 2'd0);
    // HLT, idle, START pulse, then resume
    reg_ref(16'h7001, 4'h0, 13'h0, 3'd0, 2'd0);
    for (int k = 0; k < 10; k++) push_row(4'd0, 1'b0, 3'd0, 13'h0, 3'd0, 2'd0, 1'b0);
    push_row(4'd0, 1'b0, 3'd0, 13'h0, 3'd0, 2'd0, 1'b1);
    mem_rd_exec(16'h0010, 3'd1);

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_sc", 32'(SC_Q), 0);
    chk("rst_s", 32'(S_Q), 1);
    chk("rst_i", 32'(I_Q), 0);
    chk("rst_strb", 32'(strb()), 0);
    chk("rst_bus", 32'(BUS_SEL), 0);
    RST_N = 1'b1;

    foreach (tbl[k]) begin
      IR_Q = tbl[k].ir;
      {AC_SIGN, AC_ZERO, E_Q, DR_ZERO} = tbl[k].fl;
      START = tbl[k].start;
      sb.push_back(tbl[k].e);
      sb_idx.push_back(k);
      @(posedge CLK);
      #1;
    end
    chk("sb_drained", 32'(sb.size()), 0);

    // Reset in the middle of an STA write must drop MEM_WR at once
    IR_Q = 16'h3010;
    {AC_SIGN, AC_ZERO, E_Q, DR_ZERO} = 4'h0;
    w = 0;
    while (SC_Q != 4'd4 && w < 10) begin
      @(posedge CLK);
      #1;
      w++;
    end
    chk("sta_t4_sc", 32'(SC_Q), 4);
    chk("sta_t4_wr", 32'(MEM_WR), 1);
    chk("sta_t4_bus", 32'(BUS_SEL), 4);
    RST_N = 1'b0;
    #1;
    chk("abort_strb", 32'(strb()), 0);
    chk("abort_bus", 32'(BUS_SEL), 0);
    chk("abort_sc", 32'(SC_Q), 0);
    chk("abort_s", 32'(S_Q), 1);
    @(posedge CLK);
    #1;
    chk("abort_hold_strb", 32'(strb()), 0);
    RST_N = 1'b1;
    #1;
    chk("restart_t0_ldar", 32'(LD_AR), 1);
    chk("restart_t0_bus", 32'(BUS_SEL), 2);
    @(posedge CLK);
    #1;
    chk("restart_t1_sc", 32'(SC_Q), 1);
    chk("restart_t1_strb", 32'(strb()), 32'(MRd | MLdIr | MInrPc));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
